// File: rtl/channel_buffer.sv
// Elastic buffer between two 2-phase (toggle) req/ack flit channels.
// Accepted flits queue in a DEPTH-entry FIFO and are re-issued in order downstream.
module channel_buffer #(
  parameter int ID   = 0,
  parameter int SIZE = 8,
  parameter int ADDR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_req,
  output logic            in_ack,
  input  logic [SIZE-1:0] in_data,
  output logic            out_req,
  input  logic            out_ack,
  output logic [SIZE-1:0] out_data,
  output logic [ADDR:0]   count,
  output logic [7:0]      delivered
);

  localparam int DEPTH = 1 << ADDR;

  logic [SIZE-1:0] mem [DEPTH];

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            in_ack_q, in_ack_d;
  logic            out_req_q, out_req_d;
  logic [SIZE-1:0] out_data_q, out_data_d;
  logic [7:0]      delivered_q, delivered_d;
  logic            wait_q, wait_d;

  logic in_pending, out_busy, full, pop, accept, ack_done;

  // wait_q marks an issued flit whose ack has not been consumed yet; the
  // launch of the next flit is held off until the cycle after that ack.
  always_comb begin
    in_pending = in_req ^ in_ack_q;
    out_busy   = out_req_q ^ out_ack;
    full       = count_q[ADDR];
    ack_done   = wait_q & ~out_busy;
    pop        = ~wait_q & (count_q != '0);
    accept     = in_pending & (~full | pop);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_ack_d    = in_ack_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    delivered_d = delivered_q;
    wait_d      = wait_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      in_ack_d = ~in_ack_q;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_data_d = mem[rd_ptr_q];
      out_req_d  = ~out_req_q;
      wait_d     = 1'b1;
    end else if (ack_done) begin
      wait_d = 1'b0;
      if (delivered_q != 8'hFF) begin
        delivered_d = delivered_q + 8'd1;
      end
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; a same-edge write and read of one slot returns the old flit.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ack_q    <= 1'b0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      delivered_q <= '0;
      wait_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ack_q    <= in_ack_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      delivered_q <= delivered_d;
      wait_q      <= wait_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out_req   = out_req_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign delivered = delivered_q;

endmodule

// File: tb/tb_channel_buffer.sv
// Bench for channel_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_channel_buffer;
  localparam int ID    = 0;
  localparam int SIZE  = 8;
  localparam int ADDR  = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_req = 1'b0;
  logic            out_ack = 1'b0;
  logic [SIZE-1:0] in_data = '0;
  logic            in_ack;
  logic            out_req;
  logic [SIZE-1:0] out_data;
  logic [ADDR:0]   count;
  logic [7:0]      delivered;

  int total = 0;
  int bad   = 0;

  channel_buffer #(.ID(ID), .SIZE(SIZE), .ADDR(ADDR)) dut (
    .clk(clk), .reset(reset),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .count(count), .delivered(delivered)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired, got no handshake expected one", name);
  endtask

  // Reference: a plain flit queue plus the one flit parked on the output register.
  logic [SIZE-1:0] mq[$];
  logic            m_in_ack = 1'b0;
  logic            m_out_req = 1'b0;
  logic            m_wait = 1'b0;
  logic [SIZE-1:0] m_out_data = '0;
  logic [7:0]      m_deliv = '0;
  logic            m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_in_ack   = 1'b0;
      m_out_req  = 1'b0;
      m_wait     = 1'b0;
      m_out_data = '0;
      m_deliv    = '0;
    end else begin
      m_pop = 1'b0;
      if (m_wait) begin
        if (m_out_req == out_ack) begin
          m_wait = 1'b0;
          if (m_deliv != 8'hFF) m_deliv = m_deliv + 8'd1;
        end
      end else if (mq.size() > 0) begin
        m_pop = 1'b1;
      end
      if (m_pop) begin
        m_out_data = mq.pop_front();
        m_out_req  = ~m_out_req;
        m_wait     = 1'b1;
      end
      if ((in_req != m_in_ack) && (mq.size() < DEPTH)) begin
        mq.push_back(in_data);
        m_in_ack = ~m_in_ack;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ack", in_ack, m_in_ack);
    check("out_req", out_req, m_out_req);
    check("out_data", out_data, m_out_data);
    check("count", count, mq.size());
    check("delivered", delivered, m_deliv);
  end

  logic [SIZE-1:0] rx[$];

  task automatic send(input logic [SIZE-1:0] v, input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    while (in_ack !== in_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("send");
    @(posedge clk);
    #1;
    in_data = v;
    in_req  = ~in_req;
  endtask

  task automatic recv(input int dly);
    int n = 0;
    while (out_req === out_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("recv");
    rx.push_back(out_data);
    $display("Buffer %0d: flit %0h taken downstream", ID, out_data);
    repeat (dly) @(posedge clk);
    @(posedge clk);
    #1;
    out_ack = ~out_ack;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_req  = 1'b0;
    out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ack", in_ack, 0);
    check("rst_count", count, 0);
    reset = 1'b0;

    // single flit
    send(8'h04, 0);
    @(posedge clk); #1;
    check("t2_in_ack", in_ack, 1);
    check("t2_out_req_early", out_req, 0);
    @(posedge clk); #1;
    check("t2_out_req", out_req, 1);
    check("t2_out_data", out_data, 8'h04);
    recv(0);
    @(posedge clk); #1;
    check("t2_delivered", delivered, 1);
    check("t2_count", count, 0);

    // backpressure: six flits, no downstream ack
    for (int i = 1; i <= 6; i++) send(i[SIZE-1:0], 0);
    repeat (10) @(posedge clk);
    #1;
    check("t3_out_data", out_data, 1);
    check("t3_count", count, 4);
    check("t3_in_ack_held", in_ack, 0);

    // ack flit 1: delivery edge, then pop+accept on the same edge
    out_ack = ~out_ack;
    @(posedge clk); #1;
    check("t4_delivered", delivered, 2);
    check("t4_in_ack_still", in_ack, 0);
    @(posedge clk); #1;
    check("t4_out_data", out_data, 2);
    check("t4_in_ack", in_ack, 1);
    check("t4_count", count, 4);

    // asynchronous reset between edges
    #2;
    reset   = 1'b1;
    in_req  = 1'b0;
    out_ack = 1'b0;
    #1;
    check("t1_in_ack", in_ack, 0);
    check("t1_out_req", out_req, 0);
    check("t1_out_data", out_data, 0);
    check("t1_count", count, 0);
    check("t1_delivered", delivered, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // ordering under random pacing
    rx.delete();
    fork
      begin
        for (int i = 1; i <= 20; i++) send(i[SIZE-1:0], $urandom_range(0, 5));
      end
      begin
        for (int j = 0; j < 20; j++) recv($urandom_range(0, 5));
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("t5_rx_len", rx.size(), 20);
    for (int i = 0; i < rx.size(); i++) check("t5_order", rx[i], i + 1);
    check("t5_delivered", delivered, 20);

    // reset while busy with three queued
    for (int i = 0; i < 4; i++) send(8'h10 + i[SIZE-1:0], 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_count", count, 3);
    check("t6_busy", out_req ^ out_ack, 1);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("t6_quiet_in_ack", in_ack, 0);
    check("t6_quiet_out_req", out_req, 0);
    rx.delete();
    send(8'hAA, 0);
    recv(0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_rx_len", rx.size(), 1);
    if (rx.size() > 0) check("t6_rx", rx[0], 8'hAA);
    check("t6_delivered", delivered, 1);
    check("t6_count_end", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
